// File: rtl/wb_master_pkg.sv
// ---------------------------------------------------------------------------
// wb_master_pkg
// Shared definitions for the Wishbone burst master: the controller state
// enum, Wishbone cycle-type (CTI) codes and the ack-timeout limit used when
// the block is built with WB_MASTER_TIMEOUT_EN.
// ---------------------------------------------------------------------------
package wb_master_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  localparam int                 TIMER_W       = 10;
  localparam logic [TIMER_W-1:0] TIMEOUT_LIMIT = 10'd1023;

endpackage

// File: rtl/wb_ack_timer.sv
// ---------------------------------------------------------------------------
// wb_ack_timer
// Counts consecutive burst cycles in which the slave has not acknowledged.
// Only instantiated when WB_MASTER_TIMEOUT_EN is defined.
//
// Ports:
//   clk, rst  clock and asynchronous active-high reset
//   run       a burst cycle without ack: count up
//   clear     ack seen or not bursting: restart from zero
//   expired   counter has reached TIMEOUT_LIMIT
// ---------------------------------------------------------------------------
module wb_ack_timer
  import wb_master_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic clear,
  output logic expired
);

  logic [TIMER_W-1:0] count_q, count_d;

  assign expired = (count_q == TIMEOUT_LIMIT);

  // Holds at the limit so the abort condition stays visible until cleared.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (run && !expired) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/wb_burst_master.sv
// ---------------------------------------------------------------------------
// wb_burst_master
// Turns a single command (address, beat count, direction, byte enables) into
// one Wishbone incrementing burst towards the SDRAM controller.
//
// Ports:
//   wb_clk_i, wb_rst_i        clock, asynchronous active-high reset
//   sdr_init_done             commands are only accepted once SDRAM is ready
//   cmd_valid/cmd_ready       command handshake; cmd_we/addr/len/sel payload
//   wr_data/wr_pop            write beat source; pop = beat consumed
//   rd_valid/rd_data          read beat sink, no backpressure
//   busy, err                 burst in progress, timeout abort pulse
//   wb_*_i (out), wb_*_o (in) Wishbone master side
//
// Build option: define WB_MASTER_TIMEOUT_EN to abort bursts whose slave stops
// acknowledging; otherwise the block waits indefinitely and err stays 0.
// ---------------------------------------------------------------------------
module wb_burst_master
  import wb_master_pkg::*;
#(
  parameter int dw        = 32,
  parameter int APP_AW    = 26,
  parameter int MAX_BURST = 16
) (
  input  logic                         wb_clk_i,
  input  logic                         wb_rst_i,
  input  logic                         sdr_init_done,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic                         cmd_we,
  input  logic [APP_AW-1:0]            cmd_addr,
  input  logic [$clog2(MAX_BURST)-1:0] cmd_len,
  input  logic [dw/8-1:0]              cmd_sel,
  input  logic [dw-1:0]                wr_data,
  output logic                         wr_pop,
  output logic                         rd_valid,
  output logic [dw-1:0]                rd_data,
  output logic                         busy,
  output logic                         err,
  output logic                         wb_stb_i,
  output logic                         wb_cyc_i,
  output logic                         wb_we_i,
  output logic [APP_AW-1:0]            wb_addr_i,
  output logic [dw-1:0]                wb_dat_i,
  output logic [dw/8-1:0]              wb_sel_i,
  output logic [2:0]                   wb_cti_i,
  input  logic                         wb_ack_o,
  input  logic [dw-1:0]                wb_dat_o
);

  localparam int LW = $clog2(MAX_BURST);

  state_t            state_q, state_d;
  logic              cyc_q, cyc_d;
  logic              we_q, we_d;
  logic [APP_AW-1:0] addr_q, addr_d;
  logic [dw-1:0]     dat_q, dat_d;
  logic [dw/8-1:0]   sel_q, sel_d;
  logic [2:0]        cti_q, cti_d;
  logic [LW-1:0]     rem_q, rem_d;
  logic              rd_valid_q, rd_valid_d;
  logic [dw-1:0]     rd_data_q, rd_data_d;
  logic              err_q, err_d;

  logic accept;
  logic last_beat;
  logic timeout;

  // Reset gating keeps cmd_ready low while reset is held, even though the
  // state already reads IDLE.
  assign cmd_ready = (state_q == ST_IDLE) && sdr_init_done && !wb_rst_i;
  assign accept    = cmd_valid && cmd_ready;
  assign last_beat = (rem_q == '0);

  // The beat is popped in the same cycle its data is captured into wb_dat_i.
  assign wr_pop = (accept && cmd_we) ||
                  ((state_q == ST_BURST) && we_q && wb_ack_o && !last_beat);

`ifdef WB_MASTER_TIMEOUT_EN
  wb_ack_timer u_ack_timer (
    .clk     (wb_clk_i),
    .rst     (wb_rst_i),
    .run     ((state_q == ST_BURST) && !wb_ack_o),
    .clear   ((state_q != ST_BURST) || wb_ack_o),
    .expired (timeout)
  );
  assign err = err_q;
`else
  assign timeout = 1'b0;
  assign err     = 1'b0;
`endif

  assign busy      = (state_q != ST_IDLE);
  assign wb_cyc_i  = cyc_q;
  assign wb_stb_i  = cyc_q;
  assign wb_we_i   = we_q;
  assign wb_addr_i = addr_q;
  assign wb_dat_i  = dat_q;
  assign wb_sel_i  = sel_q;
  assign wb_cti_i  = cti_q;
  assign rd_valid  = rd_valid_q;
  assign rd_data   = rd_data_q;

  always_comb begin
    state_d    = state_q;
    cyc_d      = cyc_q;
    we_d       = we_q;
    addr_d     = addr_q;
    dat_d      = dat_q;
    sel_d      = sel_q;
    cti_d      = cti_q;
    rem_d      = rem_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    err_d      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_BURST;
          cyc_d   = 1'b1;
          we_d    = cmd_we;
          addr_d  = cmd_addr;
          sel_d   = cmd_sel;
          rem_d   = cmd_len;
          cti_d   = (cmd_len == '0) ? CTI_CLASSIC : CTI_INCR;
          if (cmd_we) begin
            dat_d = wr_data;
          end
        end
      end

      ST_BURST: begin
        if (wb_ack_o) begin
          addr_d = addr_q + APP_AW'(dw / 8);
          if (!we_q) begin
            rd_valid_d = 1'b1;
            rd_data_d  = wb_dat_o;
          end
          if (last_beat) begin
            state_d = ST_DONE;
            cyc_d   = 1'b0;
            cti_d   = CTI_CLASSIC;
          end else begin
            rem_d = rem_q - LW'(1);
            // The beat about to be presented is the last one when only one
            // more remains after this ack.
            cti_d = (rem_q == LW'(1)) ? CTI_EOB : CTI_INCR;
            if (we_q) begin
              dat_d = wr_data;
            end
          end
        end else if (timeout) begin
          state_d = ST_DONE;
          cyc_d   = 1'b0;
          cti_d   = CTI_CLASSIC;
          err_d   = 1'b1;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
        cyc_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q    <= ST_IDLE;
      cyc_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      dat_q      <= '0;
      sel_q      <= '0;
      cti_q      <= CTI_CLASSIC;
      rem_q      <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cyc_q      <= cyc_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      dat_q      <= dat_d;
      sel_q      <= sel_d;
      cti_q      <= cti_d;
      rem_q      <= rem_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      err_q      <= err_d;
    end
  end

endmodule

// File: doc/wb_burst_master.md
WB_BURST_MASTER -- requirements
Module: wb_burst_master

Interface
REQ-001 The block SHALL have these parameters:
  dw  32  Wishbone data width in bits; multiple of 8.
  APP_AW  26  Wishbone byte-address width.
  MAX_BURST  16  maximum beats per command; power of two, at most 256.
REQ-002 The block SHALL have these ports:
  wb_clk_i  in  1  single clock for all logic.
  wb_rst_i  in  1  reset; asynchronous, active-high.
  sdr_init_done  in  1  SDRAM initialisation complete.
  cmd_valid  in  1  command request.
  cmd_ready  out  1  command accepted this cycle when high with cmd_valid.
  cmd_we  in  1  1 = write, 0 = read.
  cmd_addr  in  APP_AW  start byte address, aligned to dw/8.
  cmd_len  in  $clog2(MAX_BURST)  beats minus 1.
  cmd_sel  in  dw/8  byte enables for every beat.
  wr_data  in  dw  current write beat.
  wr_pop  out  1  pulse; wr_data was consumed, present the next beat.
  rd_valid  out  1  pulse; rd_data holds one read beat.
  rd_data  out  dw  read beat.
  busy  out  1  burst in progress.
  err  out  1  one-cycle pulse on timeout abort (macro only; tied 0 otherwise).
  wb_stb_i, wb_cyc_i, wb_we_i  out  1  Wishbone strobe, cycle and write enable.
  wb_addr_i  out  APP_AW  Wishbone address.
  wb_dat_i  out  dw  Wishbone write data.
  wb_sel_i  out  dw/8  Wishbone byte select.
  wb_cti_i  out  3  Wishbone cycle type identifier.
  wb_ack_o  in  1  Wishbone acknowledge.
  wb_dat_o  in  dw  Wishbone read data.

Function
REQ-003 State machine: IDLE, BURST, DONE. IDLE->BURST on cmd_valid&&cmd_ready; BURST->DONE on ack of the final beat; DONE->IDLE after exactly one cycle.
REQ-004 cmd_ready SHALL be high only in IDLE with sdr_init_done=1; commands are ignored while sdr_init_done=0.
REQ-005 On accept, the block SHALL register addr, len, we and sel, and assert wb_cyc_i and wb_stb_i on the next cycle.
REQ-006 wb_cyc_i and wb_stb_i SHALL stay high continuously from the first beat until the cycle in which the final wb_ack_o is sampled, and SHALL go low on the following cycle.
REQ-007 wb_cti_i SHALL be:
  3'b000 for a single-beat command (cmd_len=0);
  otherwise 3'b010 on every beat but the last, and 3'b111 on the last.
REQ-008 On each sampled ack, wb_addr_i SHALL advance by dw/8, wrapping modulo 2^APP_AW.
REQ-009 Write: wb_dat_i SHALL be loaded from wr_data at command accept and on each non-final ack; wr_pop SHALL pulse on each of those same cycles, totalling cmd_len+1 pops.
REQ-010 Read: on each ack, rd_valid SHALL pulse one cycle later with rd_data equal to the registered wb_dat_o; there is no backpressure.
REQ-011 busy SHALL be high in BURST and DONE.
REQ-012 wb_ack_o seen outside BURST SHALL be ignored.
REQ-013 If sdr_init_done falls mid-burst, the burst SHALL still complete.

Reset
REQ-014 While wb_rst_i is high, all outputs SHALL be 0 and the state SHALL be IDLE, asynchronously.
REQ-015 Reset asserted mid-burst SHALL drop wb_cyc_i and wb_stb_i immediately and SHALL produce no further wr_pop or rd_valid.

Configuration
REQ-016 Macro WB_MASTER_TIMEOUT_EN:
  defined: a 10-bit counter, cleared on each ack, counts BURST cycles without ack. At 1023, cyc/stb SHALL drop, err SHALL pulse, and the state SHALL go to DONE.
  undefined: no counter; the block waits for ack indefinitely; err is tied 0.

Structure
REQ-017 Package wb_master_pkg SHALL hold the state enum and the CTI constants CTI_CLASSIC, CTI_INCR and CTI_EOB.
REQ-018 The timeout counter SHALL be sub-module wb_ack_timer, instantiated only under WB_MASTER_TIMEOUT_EN.

Verification
REQ-019 Single write, addr 0x100, len 0, slave acks in the 2nd cycle -> cti 000, one wr_pop, cyc high for 2 cycles.
REQ-020 Read burst, len 3, addr 0x0, ack every cycle -> addresses 0x0/0x4/0x8/0xC, cti 010,010,010,111, four rd_valid pulses.
REQ-021 Write burst, len 7, ack every other cycle -> stb held high throughout, 8 wr_pops, wb_dat_i sequence matches wr_data.
REQ-022 Address wrap: APP_AW=26, addr 0x3FFFFFC, len 1 -> second beat at 0x0000000.
REQ-023 cmd_valid with sdr_init_done=0 -> cmd_ready=0 and no cycle; reset mid-burst -> cyc=0 in the same cycle.
REQ-024 With WB_MASTER_TIMEOUT_EN, a slave that never acks -> err pulses at cycle 1023 and the state returns to IDLE.
